// File: rtl/affine_pkg.sv
// Shared types for the affine point coprocessor: FSM states,
// coefficient bank indices and the default-width coefficient bank.
package affine;

   localparam int N_DEF  = 8;
   localparam int CW_DEF = 8;
   localparam int F_DEF  = 6;

   typedef enum logic [2:0] {
      IDLE,
      M11,
      M12,
      M21,
      M22,
      DONE
   } tAffState;

   localparam logic [2:0] C_A11 = 3'd0;
   localparam logic [2:0] C_A12 = 3'd1;
   localparam logic [2:0] C_A21 = 3'd2;
   localparam logic [2:0] C_A22 = 3'd3;
   localparam logic [2:0] C_B1  = 3'd4;
   localparam logic [2:0] C_B2  = 3'd5;

   typedef struct packed {
      logic signed [CW_DEF-1:0] a11;
      logic signed [CW_DEF-1:0] a12;
      logic signed [CW_DEF-1:0] a21;
      logic signed [CW_DEF-1:0] a22;
      logic signed [N_DEF-1:0]  b1;
      logic signed [N_DEF-1:0]  b2;
   } tCoefBank;

endpackage

// File: rtl/affine_mac.sv
// Shared multiplier/accumulator with floor shift, offset add and
// wrap, or clamp when AFFINE_SAT_EN is defined.
module affine_mac
   import affine::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF,
   parameter int F  = F_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 acc_en,
   input  logic signed [CW-1:0] coef,
   input  logic signed [N-1:0]  opnd,
   input  logic signed [N-1:0]  offs,
   output logic signed [N-1:0]  res,
   output logic                 sat
);

   localparam int PW = N + CW;
   localparam int AW = PW + 1;

   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_nxt;

   assign prod    = PW'(coef) * PW'(opnd);
   assign acc_nxt = clr ? AW'(prod) : acc + AW'(prod);

   always_ff @(posedge clk) begin
      if (reset)
         acc <= '0;
      else if (clr || acc_en)
         acc <= acc_nxt;
   end

`ifdef AFFINE_SAT_EN
   localparam int SW = AW + 1;
   localparam logic signed [SW-1:0] MAXV =
      SW'((1 << (N - 1)) - 1);
   localparam logic signed [SW-1:0] MINV =
      SW'(-(1 << (N - 1)));

   logic signed [AW-1:0] shifted;
   logic signed [SW-1:0] sum;

   assign shifted = acc_nxt >>> F;
   assign sum     = SW'(shifted) + SW'(offs);

   always_comb begin
      res = sum[N-1:0];
      sat = 1'b0;
      if (sum > MAXV) begin
         res = MAXV[N-1:0];
         sat = 1'b1;
      end else if (sum < MINV) begin
         res = MINV[N-1:0];
         sat = 1'b1;
      end
   end
`else
   // Only the low N bits survive, so the add can run at N bits.
   assign res = N'(acc_nxt >>> F) + offs;
   assign sat = 1'b0;
`endif

endmodule

// File: rtl/affine_point_engine.sv
// Sequential 2-D affine point engine, four MAC cycles per point.
// Define AFFINE_SAT_EN to clamp results instead of wrapping.
module affine_point_engine
   import affine::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF,
   parameter int F  = F_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 coef_we,
   input  logic [2:0]           coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 coef_err,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [N-1:0]  in_x,
   input  logic signed [N-1:0]  in_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [N-1:0]  out_x,
   output logic signed [N-1:0]  out_y,
   output logic                 out_sat
);

   typedef struct packed {
      logic signed [CW-1:0] a11;
      logic signed [CW-1:0] a12;
      logic signed [CW-1:0] a21;
      logic signed [CW-1:0] a22;
      logic signed [N-1:0]  b1;
      logic signed [N-1:0]  b2;
   } coef_bank_t;

   tAffState   state;
   tAffState   state_nxt;
   coef_bank_t coef;

   logic signed [N-1:0]  x_q;
   logic signed [N-1:0]  y_q;
   logic                 sat_x;
   logic                 sat_q;
   logic                 accept;
   logic                 wr_ok;
   logic                 mac_clr;
   logic                 mac_acc;
   logic signed [CW-1:0] mac_coef;
   logic signed [N-1:0]  mac_opnd;
   logic signed [N-1:0]  mac_offs;
   logic signed [N-1:0]  mac_res;
   logic                 mac_sat;

   assign accept  = (state == IDLE) && in_valid;
   assign wr_ok   = coef_we && (state == IDLE) && !in_valid;
   assign out_sat = sat_q;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mac_clr   = 1'b0;
      mac_acc   = 1'b0;
      mac_coef  = coef.a11;
      mac_opnd  = x_q;
      mac_offs  = coef.b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_nxt = M11;
         end
         M11: begin
            mac_clr   = 1'b1;
            state_nxt = M12;
         end
         M12: begin
            mac_acc   = 1'b1;
            mac_coef  = coef.a12;
            mac_opnd  = y_q;
            state_nxt = M21;
         end
         M21: begin
            mac_clr   = 1'b1;
            mac_coef  = coef.a21;
            state_nxt = M22;
         end
         M22: begin
            mac_acc   = 1'b1;
            mac_coef  = coef.a22;
            mac_opnd  = y_q;
            mac_offs  = coef.b2;
            state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         out_x <= '0;
         out_y <= '0;
         sat_x <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         if (accept) begin
            x_q <= in_x;
            y_q <= in_y;
         end
         if (state == M12) begin
            out_x <= mac_res;
            sat_x <= mac_sat;
         end
         if (state == M22) begin
            out_y <= mac_res;
            sat_q <= sat_x | mac_sat;
         end
      end
   end

   // Writes only land while idle with no point arriving.
   always_ff @(posedge clk) begin
      if (reset) begin
         coef.a11 <= CW'(1 << F);
         coef.a12 <= '0;
         coef.a21 <= '0;
         coef.a22 <= CW'(1 << F);
         coef.b1  <= '0;
         coef.b2  <= '0;
         coef_err <= 1'b0;
      end else begin
         coef_err <= coef_we && !wr_ok && (coef_addr < 3'd6);
         if (wr_ok) begin
            unique case (1'b1)
               coef_addr == C_A11: coef.a11 <= coef_data;
               coef_addr == C_A12: coef.a12 <= coef_data;
               coef_addr == C_A21: coef.a21 <= coef_data;
               coef_addr == C_A22: coef.a22 <= coef_data;
               coef_addr == C_B1:  coef.b1  <= N'(coef_data);
               coef_addr == C_B2:  coef.b2  <= N'(coef_data);
               default: ;
            endcase
         end
      end
   end

   affine_mac #(
      .N  (N),
      .CW (CW),
      .F  (F)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clr    (mac_clr),
      .acc_en (mac_acc),
      .coef   (mac_coef),
      .opnd   (mac_opnd),
      .offs   (mac_offs),
      .res    (mac_res),
      .sat    (mac_sat)
   );

endmodule

// File: tb/tb_affine_point_engine.sv
// Bench for affine_point_engine: fixed vectors, corner sequences
// and random points against an integer reference model.
module tb_affine_point_engine;

   localparam int N  = 8;
   localparam int CW = 8;
   localparam int F  = 6;

`ifdef AFFINE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 coef_we;
   logic [2:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 coef_err;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [N-1:0]  in_x;
   logic signed [N-1:0]  in_y;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [N-1:0]  out_x;
   logic signed [N-1:0]  out_y;
   logic                 out_sat;

   always #5 clk = ~clk;

   affine_point_engine #(
      .N  (N),
      .CW (CW),
      .F  (F)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_sat   (out_sat)
   );

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      string name;
      int a11, a12, a21, a22, b1, b2;
      int x, y;
      int ex, ey, es;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input int act,
                        input int exp);
      n_tot++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d",
                  name, act, exp);
   endtask

   // Floor division by 2^F done with plain integer arithmetic.
   function automatic int fdiv(input int p);
      int q;
      q = p / (1 << F);
      if ((p % (1 << F)) != 0 && p < 0)
         q = q - 1;
      return q;
   endfunction

   function automatic void model(input int a, input int b,
                                 input int off, input int x,
                                 input int y, output int r,
                                 output int s);
      int v;
      v = fdiv(a * x + b * y) + off;
      s = 0;
      if (SAT) begin
         if (v > 127) begin
            v = 127;
            s = 1;
         end else if (v < -128) begin
            v = -128;
            s = 1;
         end
         r = v;
      end else begin
         r = ((v % 256) + 256) % 256;
         if (r > 127)
            r = r - 256;
      end
   endfunction

   task automatic wr(input int addr, input int data);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 3'(addr);
      coef_data = CW'(data);
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   task automatic set_coefs(input int a11, input int a12,
                            input int a21, input int a22,
                            input int b1, input int b2);
      wr(0, a11);
      wr(1, a12);
      wr(2, a21);
      wr(3, a22);
      wr(4, b1);
      wr(5, b2);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Returns with out_valid seen; lat counts edges from accept
   // to the first edge that can complete the output handshake.
   task automatic send(input int x, input int y, output int lat,
                       output int rx, output int ry,
                       output int rs);
      int k;
      @(negedge clk);
      in_x     = N'(x);
      in_y     = N'(y);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = N'($urandom);
      in_y     = N'($urandom);
      wait_valid(k);
      lat = k + 1;
      rx  = out_x;
      ry  = out_y;
      rs  = out_sat;
   endtask

   initial begin
      int lat, rx, ry, rs, k;
      int a[6];
      int px, py, mx, my, sx, sy;

      tbl[0] = '{"ident", 64, 0, 0, 64, 0, 0, 5, -3, 5, -3, 0};
      tbl[1] = '{"rot90", 0, -64, 64, 0, 3, -2, 10, 20,
                 -17, 8, 0};
      tbl[2] = '{"ovf", 127, 0, 0, 64, 0, 0, 100, 0,
                 SAT ? 127 : -58, 0, SAT ? 1 : 0};
      tbl[3] = '{"neg2", -128, 0, 0, 64, 0, 0, -128, -128,
                 SAT ? 127 : 0, -128, SAT ? 1 : 0};
      tbl[4] = '{"floor", 1, 0, 0, 0, 0, 5, -1, 77, -1, 5, 0};
      tbl[5] = '{"mix", 32, 16, -48, 96, -7, 9, 50, -40,
                 8, -89, 0};

      reset     = 1'b1;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_coef_err", coef_err, 0);

      // Identity coefficients straight out of reset.
      send(5, -3, lat, rx, ry, rs);
      check("id_lat", lat, 5);
      check("id_x", rx, 5);
      check("id_y", ry, -3);
      check("id_sat", rs, 0);

      for (int i = 0; i < 6; i++) begin
         set_coefs(tbl[i].a11, tbl[i].a12, tbl[i].a21,
                   tbl[i].a22, tbl[i].b1, tbl[i].b2);
         send(tbl[i].x, tbl[i].y, lat, rx, ry, rs);
         check({tbl[i].name, "_lat"}, lat, 5);
         check({tbl[i].name, "_x"}, rx, tbl[i].ex);
         check({tbl[i].name, "_y"}, ry, tbl[i].ey);
         check({tbl[i].name, "_sat"}, rs, tbl[i].es);
      end

      // Backpressure: result held while downstream stalls.
      set_coefs(64, 0, 0, 64, 0, 0);
      out_ready = 1'b0;
      send(33, -44, lat, rx, ry, rs);
      check("bp_lat", lat, 5);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_x     = 8'sd99;
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_x", out_x, 33);
         check("bp_hold_y", out_y, -44);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_valid", out_valid, 0);
      check("bp_rel_ready", in_ready, 1);
      check("bp_rel_x", out_x, 33);

      // Coefficient write while busy is dropped.
      @(negedge clk);
      in_x     = 8'sd21;
      in_y     = -8'sd4;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'sd32;
      @(negedge clk);
      coef_we = 1'b0;
      check("busy_err_pulse", coef_err, 1);
      @(negedge clk);
      check("busy_err_clear", coef_err, 0);
      wait_valid(k);
      check("busy_valid", out_valid, 1);
      check("busy_x", out_x, 21);
      check("busy_y", out_y, -4);
      send(12, 12, lat, rx, ry, rs);
      check("busy_old_a11", rx, 12);

      // Write in the same cycle as an accepted point.
      @(negedge clk);
      in_x      = 8'sd3;
      in_y      = 8'sd4;
      in_valid  = 1'b1;
      coef_we   = 1'b1;
      coef_addr = 3'd1;
      coef_data = 8'sd64;
      @(negedge clk);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      check("accept_err", coef_err, 1);
      wait_valid(k);
      check("accept_x", out_x, 3);

      wr(6, 55);
      check("addr6_no_err", coef_err, 0);
      send(-7, 9, lat, rx, ry, rs);
      check("addr6_x", rx, -7);
      check("addr6_y", ry, 9);

      // Reset in M21 aborts the point and restores identity.
      wr(0, 32);
      @(negedge clk);
      in_x     = 8'sd40;
      in_y     = 8'sd8;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_x", out_x, 0);
      check("mid_rst_y", out_y, 0);
      send(40, 8, lat, rx, ry, rs);
      check("mid_rst_id_x", rx, 40);
      check("mid_rst_id_y", ry, 8);

      for (int i = 0; i < 30; i++) begin
         for (int j = 0; j < 6; j++)
            a[j] = int'($urandom_range(255)) - 128;
         px = int'($urandom_range(255)) - 128;
         py = int'($urandom_range(255)) - 128;
         set_coefs(a[0], a[1], a[2], a[3], a[4], a[5]);
         send(px, py, lat, rx, ry, rs);
         model(a[0], a[1], a[4], px, py, mx, sx);
         model(a[2], a[3], a[5], px, py, my, sy);
         check("rnd_lat", lat, 5);
         check("rnd_x", rx, mx);
         check("rnd_y", ry, my);
         check("rnd_sat", rs, (sx | sy));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
